// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: operation codes, FSM states and
// the default datapath width.
package ex_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [4:0] OP_SLL   = 5'b00000;
  localparam logic [4:0] OP_SRL   = 5'b00001;
  localparam logic [4:0] OP_SRA   = 5'b00010;
  localparam logic [4:0] OP_ROR   = 5'b00011;
  localparam logic [4:0] OP_SLLV  = 5'b00100;
  localparam logic [4:0] OP_SRLV  = 5'b00101;
  localparam logic [4:0] OP_SRAV  = 5'b00110;
  localparam logic [4:0] OP_RORV  = 5'b00111;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_DIVU  = 5'b10001;
  localparam logic [4:0] OP_MULHU = 5'b10010;
  localparam logic [4:0] OP_REMU  = 5'b10011;
  localparam logic [4:0] OP_ADD   = 5'b10110;
  localparam logic [4:0] OP_SUB   = 5'b10111;
  localparam logic [4:0] OP_AND   = 5'b11000;
  localparam logic [4:0] OP_OR    = 5'b11001;
  localparam logic [4:0] OP_XOR   = 5'b11010;
  localparam logic [4:0] OP_NOR   = 5'b11011;
  localparam logic [4:0] OP_SLT   = 5'b11111;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_MULDIV = 1'b1
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op[4:2] == 3'b100);
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage. Shifts operate on operand B; the
// variable-shift forms take the amount from A[4:0].
module ex_stage_alu
  import ex_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [4:0]       op,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             illegal
);

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   sum_s;
  logic [4:0]         sh_s;

  // Operation decode and result select
  always_comb begin
    prod_s  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    sum_s   = op[0] ? (a - b) : (a + b);
    sh_s    = op[2] ? a[4:0] : shamt;
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    casez (op)
      5'b00???: begin
        case (op[1:0])
          2'b00:   result = b << sh_s;
          2'b01:   result = b >> sh_s;
          2'b10:   result = $signed(b) >>> sh_s;
          default: result = (b >> sh_s) | (b << (WIDTH - int'(sh_s)));
        endcase
      end
      OP_MUL:   result = prod_s[WIDTH-1:0];
      OP_MULHU: result = prod_s[2*WIDTH-1:WIDTH];
      OP_DIVU:  result = a / b;
      OP_REMU:  result = a % b;
      5'b1011?: begin
        result = sum_s;
        // Subtract overflows when signs differ; add when they match.
        ovf = ((a[WIDTH-1] ^ b[WIDTH-1]) == op[0]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOR:   result = ~(a | b);
      OP_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops, multi-cycle mul/div with captured
// operands, result forwarding from the output register, and a valid/ready
// output register towards the memory stage.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [4:0]       in_shamt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs_a,
  input  logic [4:0]       in_rs_b,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_wen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic             out_zf,
  output logic             out_of,
  output logic             out_illegal
);

  localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [4:0]       cap_op_q, cap_op_d, cap_rd_q, cap_rd_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic             cap_wen_q, cap_wen_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             out_wen_q, out_wen_d, out_zf_q, out_zf_d;
  logic             out_of_q, out_of_d, out_ill_q, out_ill_d;

  logic             out_free_s, accept_s, load_s, busy_s;
  logic [WIDTH-1:0] fwd_a_s, fwd_b_s, alu_a_s, alu_b_s, alu_res_s, res_s;
  logic [4:0]       alu_op_s, alu_shamt_s;
  logic             alu_of_s, alu_ill_s;

  ex_stage_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (alu_op_s),
    .shamt   (alu_shamt_s),
    .a       (alu_a_s),
    .b       (alu_b_s),
    .result  (alu_res_s),
    .ovf     (alu_of_s),
    .illegal (alu_ill_s)
  );

  // Forwarding, ALU operand select and divide-by-zero override
  always_comb begin
    busy_s     = (state_q == ST_MULDIV);
    out_free_s = !out_valid_q || out_ready;
    in_ready   = !busy_s && out_free_s && !flush && !rst;
    accept_s   = in_valid && in_ready;
    fwd_a_s = (out_valid_q && out_wen_q && (out_rd_q != 5'd0) && (in_rs_a == out_rd_q))
              ? out_result_q : in_a;
    fwd_b_s = (out_valid_q && out_wen_q && (out_rd_q != 5'd0) && (in_rs_b == out_rd_q))
              ? out_result_q : in_b;
    if (busy_s) begin
      alu_op_s    = cap_op_q;
      alu_shamt_s = 5'd0;
      alu_a_s     = cap_a_q;
      alu_b_s     = cap_b_q;
    end else begin
      alu_op_s    = in_op;
      alu_shamt_s = in_shamt;
      alu_a_s     = fwd_a_s;
      alu_b_s     = fwd_b_s;
    end
    if (((alu_op_s == OP_DIVU) || (alu_op_s == OP_REMU)) && (alu_b_s == '0)) begin
      res_s = (alu_op_s == OP_DIVU) ? '1 : alu_a_s;
    end else begin
      res_s = alu_res_s;
    end
  end

  // FSM, capture and output-register next state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_op_d     = cap_op_q;
    cap_rd_d     = cap_rd_q;
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    cap_wen_d    = cap_wen_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wen_d    = out_wen_q;
    out_zf_d     = out_zf_q;
    out_of_d     = out_of_q;
    out_ill_d    = out_ill_q;
    load_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && is_muldiv(in_op)) begin
          state_d   = ST_MULDIV;
          cnt_d     = CNT_INIT;
          cap_op_d  = in_op;
          cap_rd_d  = in_rd;
          cap_a_d   = fwd_a_s;
          cap_b_d   = fwd_b_s;
          cap_wen_d = in_wen;
        end else begin
          load_s = accept_s;
        end
      end
      ST_MULDIV: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else if (out_free_s) begin
          load_s  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (load_s) begin
      out_valid_d  = 1'b1;
      out_result_d = res_s;
      out_rd_d     = busy_s ? cap_rd_q : in_rd;
      out_wen_d    = (busy_s ? cap_wen_q : in_wen) && !alu_ill_s;
      out_zf_d     = (res_s == '0);
      out_of_d     = alu_of_s;
      out_ill_d    = alu_ill_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (flush) begin
      state_d      = ST_IDLE;
      cnt_d        = 4'd0;
      out_valid_d  = 1'b0;
      out_result_d = '0;
      out_rd_d     = 5'd0;
      out_wen_d    = 1'b0;
      out_zf_d     = 1'b0;
      out_of_d     = 1'b0;
      out_ill_d    = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      cap_op_q     <= 5'd0;
      cap_rd_q     <= 5'd0;
      cap_a_q      <= '0;
      cap_b_q      <= '0;
      cap_wen_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= 5'd0;
      out_wen_q    <= 1'b0;
      out_zf_q     <= 1'b0;
      out_of_q     <= 1'b0;
      out_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_op_q     <= cap_op_d;
      cap_rd_q     <= cap_rd_d;
      cap_a_q      <= cap_a_d;
      cap_b_q      <= cap_b_d;
      cap_wen_q    <= cap_wen_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wen_q    <= out_wen_d;
      out_zf_q     <= out_zf_d;
      out_of_q     <= out_of_d;
      out_ill_q    <= out_ill_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_wen     = out_wen_q;
  assign out_zf      = out_zf_q;
  assign out_of      = out_of_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed ops push hand-computed results into
// a queue; a monitor branch pops and compares on every output transfer.
module tb_ex_stage;
  import ex_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        zf;
    logic        of;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_wen;
  logic [4:0]  in_op, in_shamt, in_rd, in_rs_a, in_rs_b;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_wen, out_zf, out_of, out_illegal;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  ex_stage #(.WIDTH(32), .MULDIV_LAT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_shamt(in_shamt), .in_rd(in_rd),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b),
    .in_a(in_a), .in_b(in_b), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .out_zf(out_zf), .out_of(out_of), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input string name, input logic [4:0] opc, input logic [4:0] sh,
                      input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [31:0] a, input logic [31:0] b, input logic wen,
                      input logic [31:0] eres, input logic eof, input logic eill,
                      input bit push);
    int   t;
    exp_t e;
    in_valid = 1'b1; in_op = opc; in_shamt = sh; in_rd = rd;
    in_rs_a = ra; in_rs_b = rb; in_a = a; in_b = b; in_wen = wen;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_accept: in_ready still 0 after %0d cycles, required 1", name, t);
      in_valid = 1'b0;
    end else begin
      if (push) begin
        e.res = eres; e.rd = rd; e.wen = wen & ~eill;
        e.zf = (eres == 32'd0); e.of = eof; e.ill = eill;
        exp_q.push_back(e);
        name_q.push_back(name);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic monitor();
    exp_t  e, act;
    string nm;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        act = {out_result, out_rd, out_wen, out_zf, out_of, out_illegal};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got res=%h rd=%0d, required no output", out_result, out_rd);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL %s: got res=%h rd=%0d wen=%b zf=%b of=%b ill=%b, required res=%h rd=%0d wen=%b zf=%b of=%b ill=%b",
                     nm, act.res, act.rd, act.wen, act.zf, act.of, act.ill,
                     e.res, e.rd, e.wen, e.zf, e.of, e.ill);
          end
        end
      end
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 5'd0; in_shamt = 5'd0;
    in_rd = 5'd0; in_rs_a = 5'd0; in_rs_b = 5'd0; in_a = 32'd0; in_b = 32'd0;
    in_wen = 1'b0; out_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'({out_rd, out_wen, out_zf, out_of, out_illegal}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    idle(1);

    // Arithmetic with latency-1 check
    send("add_5_7", OP_ADD, 5'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("add_latency1_valid", 32'(out_valid), 32'd1);
    idle(1);
    send("add_ovf", OP_ADD, 5'd0, 5'd1, 5'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    send("sub_zero", OP_SUB, 5'd0, 5'd1, 5'd0, 5'd0, 32'd3, 32'd3, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    send("sub_ovf", OP_SUB, 5'd0, 5'd1, 5'd0, 5'd0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Multi-cycle multiply: in_ready low for cycles 1-3, result at cycle 4
    send("mul_6_7", OP_MUL, 5'd0, 5'd2, 5'd0, 5'd0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_ready_c%0d", c), 32'(in_ready), 32'd0);
      chk($sformatf("mul_busy_valid_c%0d", c), 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("mul_c4_valid", 32'(out_valid), 32'd1);
    chk("mul_c4_ready", 32'(in_ready), 32'd1);
    idle(1);

    // Forwarding from the output register, and never from index 0
    send("fwd_add_rd3", OP_ADD, 5'd0, 5'd3, 5'd0, 5'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0, 1'b1);
    send("fwd_sll_rsb3", OP_SLL, 5'd2, 5'd4, 5'd0, 5'd3, 32'd0, 32'd0, 1'b1, 32'd48, 1'b0, 1'b0, 1'b1);
    send("nofwd_add_rd0", OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0, 1'b1);
    send("nofwd_sll_rsb0", OP_SLL, 5'd2, 5'd4, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    send("fwd_add_rd5", OP_ADD, 5'd0, 5'd5, 5'd0, 5'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0, 1'b1);
    send("fwd_mul_rsa5", OP_MUL, 5'd0, 5'd6, 5'd5, 5'd0, 32'd0, 32'd3, 1'b1, 32'd36, 1'b0, 1'b0, 1'b1);

    // Divide, remainder (including by zero) and high multiply
    send("divu_100_7", OP_DIVU, 5'd0, 5'd7, 5'd0, 5'd0, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 1'b0, 1'b1);
    send("divu_by0", OP_DIVU, 5'd0, 5'd7, 5'd0, 5'd0, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    send("remu_100_7", OP_REMU, 5'd0, 5'd7, 5'd0, 5'd0, 32'd100, 32'd7, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1);
    send("remu_by0", OP_REMU, 5'd0, 5'd7, 5'd0, 5'd0, 32'd9, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0, 1'b1);
    send("mulhu", OP_MULHU, 5'd0, 5'd7, 5'd0, 5'd0, 32'h8000_0000, 32'd4, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1);

    // Logic, compare and shifts
    send("and", OP_AND, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 32'h0000_F000, 1'b0, 1'b0, 1'b1);
    send("or", OP_OR, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 32'h0000_FFF0, 1'b0, 1'b0, 1'b1);
    send("xor", OP_XOR, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_00FF, 32'h0000_000F, 1'b1, 32'h0000_00F0, 1'b0, 1'b0, 1'b1);
    send("nor", OP_NOR, 5'd0, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    send("slt_neg", OP_SLT, 5'd0, 5'd8, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1);
    send("slt_pos", OP_SLT, 5'd0, 5'd8, 5'd0, 5'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    send("srl", OP_SRL, 5'd4, 5'd9, 5'd0, 5'd0, 32'd0, 32'h8000_0000, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 1'b1);
    send("sra", OP_SRA, 5'd4, 5'd9, 5'd0, 5'd0, 32'd0, 32'h8000_0000, 1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
    send("ror", OP_ROR, 5'd1, 5'd9, 5'd0, 5'd0, 32'd0, 32'd1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    send("sllv", OP_SLLV, 5'd0, 5'd9, 5'd0, 5'd0, 32'd3, 32'd1, 1'b1, 32'd8, 1'b0, 1'b0, 1'b1);

    // Undecodable codes
    send("illegal_11100", 5'b11100, 5'd0, 5'd10, 5'd0, 5'd0, 32'd1, 32'd2, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
    send("illegal_01000", 5'b01000, 5'd0, 5'd10, 5'd0, 5'd0, 32'd1, 32'd2, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Backpressure: output held stable, no accept while stalled
    out_ready = 1'b0;
    send("stall_add", OP_ADD, 5'd0, 5'd6, 5'd0, 5'd0, 32'd1, 32'd2, 1'b1, 32'd3, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall_result_%0d", c), out_result, 32'd3);
      chk($sformatf("stall_rd_%0d", c), 32'(out_rd), 32'd6);
      chk($sformatf("stall_in_ready_%0d", c), 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send("after_stall_xor", OP_XOR, 5'd0, 5'd7, 5'd0, 5'd0, 32'd5, 32'd5, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("valid_kept_on_reload", 32'(out_valid), 32'd1);
    idle(2);

    // Flush during MULDIV: op discarded, ready next cycle
    send("flush_mul", OP_MUL, 5'd0, 5'd2, 5'd0, 5'd0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, 1'b0, 1'b0);
    idle(1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready_next", 32'(in_ready), 32'd1);
    chk("flush_no_valid", 32'(out_valid), 32'd0);
    repeat (6) @(negedge clk);
    chk("flush_no_late_valid", 32'(out_valid), 32'd0);
    idle(1);

    // Reset during MULDIV: op discarded
    send("rst_mul", OP_MUL, 5'd0, 5'd2, 5'd0, 5'd0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_idle_ready", 32'(in_ready), 32'd1);
    idle(1);
    send("recover_add", OP_ADD, 5'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'd1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1);

    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    idle(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits.
REQ-002 Parameter MULDIV_LAT, default 4, cycles from accept to result for mul/div ops (operation 5'b100??), legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  kills the in-flight op and clears the output register.
REQ-006 in_valid / in_ready  input / output  1 / 1  upstream (decode) handshake.
REQ-007 in_op, in_shamt, in_rd, in_rs_a, in_rs_b  input  5 each  ALU operation code, shift amount, destination and source register indices.
REQ-008 in_a, in_b  input  WIDTH each  operand values from register read.
REQ-009 in_wen  input  1  op writes a register.
REQ-010 out_valid / out_ready  output / input  1 / 1  downstream (memory stage) handshake.
REQ-011 out_result  output  WIDTH  registered ALU result.
REQ-012 out_rd, out_wen, out_zf, out_of, out_illegal  output  5/1/1/1/1  destination, write enable, zero, signed overflow, undecodable op.

Function
REQ-013 Transfer occurs on a clock edge where in_valid && in_ready, and likewise for out_valid && out_ready.
REQ-014 FSM states are IDLE and MULDIV; reset and flush force IDLE.
REQ-015 in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-016 In IDLE, a non-mul/div op is computed combinationally from the in_* signals and loaded into the output register on the accept edge (latency 1).
REQ-017 In IDLE, accepting a mul/div op captures op, operands, rd and wen, loads counter with MULDIV_LAT-1, and enters MULDIV.
REQ-018 In MULDIV, the ALU is driven from the captured registers; the counter decrements each cycle while above 1.
REQ-019 At counter==1 with (!out_valid || out_ready), load the output register and go to IDLE; otherwise hold counter at 1.
REQ-020 Forwarding: if out_valid && out_wen && out_rd!=0 && in_rs_a==out_rd, operand A is replaced by out_result; same rule for B via in_rs_b; index 0 is never forwarded.
REQ-021 Forwarded values are sampled at accept time and held in the capture registers for mul/div.
REQ-022 Decode: 00??? shift, 100?? mul/div, 1011? add/sub, 11000..11011 logic, 11111 slt; any other code sets out_illegal=1, out_result=0, out_wen=0.
REQ-023 out_of = 1 only for 1011? ops on signed overflow; otherwise 0.
REQ-024 Divide by zero: quotient (10001) yields all ones and remainder (10011) yields in_a, never X.
REQ-025 out_zf = (out_result == 0), registered with the result.
REQ-026 out_valid clears on an output-transfer edge unless a new result is loaded on the same edge, in which case it stays 1.
REQ-027 out_* hold stable while out_valid && !out_ready.
REQ-028 flush has priority over load: on a flush edge, out_valid=0 and state=IDLE, and no input is accepted.

Reset
REQ-029 On rst edge: state=IDLE, counter=0, out_valid=0, out_result=0, out_rd=0, out_wen=0, out_zf=0, out_of=0, out_illegal=0.
REQ-030 rst asserted mid-MULDIV discards the op with no output produced, and rst has priority over flush.
REQ-031 in_ready = 0 during any cycle in which rst is high.

Structure
REQ-032 Shared package ex_pkg holds the operation-code constants (OP_SLL..OP_SLT), the state enum, and the WIDTH default.
REQ-033 A single sub-module, ALU, is instantiated for all arithmetic; ex_stage adds no arithmetic of its own except the divide-by-zero override.
REQ-034 Capture, counter and output registers live in ex_stage, with no other sub-modules.

Verification
REQ-035 ADD 10110, a=5, b=7, accept at cycle 0 -> cycle 1 out_valid=1, out_result=12, zf=0, of=0.
REQ-036 ADD a=0x7FFFFFFF, b=1 -> out_result=0x80000000, out_of=1; SUB 10111 with 3-3 -> out_result=0, out_zf=1.
REQ-037 MUL 10000, a=6, b=7, MULDIV_LAT=4, out_ready=1 -> in_ready=0 for cycles 1-3, out_result=42 valid at cycle 4.
REQ-038 Back-to-back ops: op1 ADD rd=3 ->12, then op2 SLL with rs_b=3, in_b=0, shamt=2 -> out_result=48 (forwarded); repeat with rd=0 -> no forwarding.
REQ-039 Hold out_ready=0 for 5 cycles with a result pending -> out_* stable, in_ready=0, and the next op is accepted only after out_ready=1.
REQ-040 DIVU 10001 with b=0 -> 0xFFFFFFFF; op 11100 -> out_illegal=1, wen=0; flush at MULDIV cycle 2 -> no output, IDLE, in_ready=1 next cycle.
